// File: rtl/sr_cmd_pkg.sv
// Shared types and defaults for the SR command sequencer.
// Holds the FSM state encoding and the default timing constants.
package sr_cmd_pkg;

   localparam int DEB_CYCLES_DEF = 4;
   localparam int PULSE_W_DEF    = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SET_PULSE = 2'd1,
      RST_PULSE = 2'd2,
      WAIT_REL  = 2'd3
   } sr_state_e;

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// Button inputs and SR latch command outputs of the sequencer.
// master drives the buttons, slave is the sequencer itself.
interface sr_cmd_sequencer_if;

   logic btn_set;
   logic btn_rst;
   logic S;
   logic R;
   logic busy;
   logic conflict;

   modport master (
      output btn_set,
      output btn_rst,
      input  S,
      input  R,
      input  busy,
      input  conflict
   );

   modport slave (
      input  btn_set,
      input  btn_rst,
      output S,
      output R,
      output busy,
      output conflict
   );

endinterface

// File: rtl/sr_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer.
// rise is a one-cycle event registered together with the level flip.
module sr_debounce
   import sr_cmd_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync  <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         cnt   <= '0;
      end else begin
         sync <= {sync[0], btn};
         rise <= 1'b0;
         // any sample agreeing with the level restarts the count
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES)) begin
            level <= sync[1];
            rise  <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns two bouncy pushbuttons into clean, mutually exclusive
// S/R command pulses for a downstream SR latch.
module sr_cmd_sequencer
   import sr_cmd_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int PULSE_W    = PULSE_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   sr_cmd_sequencer_if.slave   bus
);

   localparam int PW = $clog2(PULSE_W + 1);

   logic set_lvl;
   logic set_rise;
   logic rst_lvl;
   logic rst_rise;

   sr_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb_set (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (bus.btn_set),
      .level (set_lvl),
      .rise  (set_rise)
   );

   sr_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb_rst (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (bus.btn_rst),
      .level (rst_lvl),
      .rise  (rst_rise)
   );

   sr_state_e     state;
   logic [PW-1:0] pcnt;
   logic          s_q;
   logic          r_q;
   logic          busy_q;
   logic          conf_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         pcnt   <= '0;
         s_q    <= 1'b0;
         r_q    <= 1'b0;
         busy_q <= 1'b0;
         conf_q <= 1'b0;
      end else begin
         conf_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (set_lvl && rst_lvl && (set_rise || rst_rise)) begin
                  state  <= WAIT_REL;
                  conf_q <= 1'b1;
                  busy_q <= 1'b1;
               end else if (set_rise && !rst_lvl) begin
                  state  <= SET_PULSE;
                  s_q    <= 1'b1;
                  busy_q <= 1'b1;
                  pcnt   <= PW'(1);
               end else if (rst_rise && !set_lvl) begin
                  state  <= RST_PULSE;
                  r_q    <= 1'b1;
                  busy_q <= 1'b1;
                  pcnt   <= PW'(1);
               end
            end
            // buttons are ignored until the pulse has run its length
            SET_PULSE, RST_PULSE: begin
               if (pcnt == PW'(PULSE_W)) begin
                  s_q   <= 1'b0;
                  r_q   <= 1'b0;
                  state <= WAIT_REL;
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            end
            WAIT_REL: begin
               if (!set_lvl && !rst_lvl) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.S        = s_q;
   assign bus.R        = r_q;
   assign bus.busy     = busy_q;
   assign bus.conflict = conf_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer with an event scoreboard.
// Expected S/R/conflict pulses are queued at stimulus time.
module tb_sr_cmd_sequencer;

   logic clk;
   logic rst_n;
   int   cyc;
   int   total;
   int   bad;

   sr_cmd_sequencer_if bus ();

   sr_cmd_sequencer #(
      .DEB_CYCLES (4),
      .PULSE_W    (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int start;
      int width;
   } ev_t;

   ev_t  exq [$];
   int   st   [3];
   int   wexp [3];
   logic pv   [3];
   logic cv   [3];

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int k, input int s, input int w);
      ev_t e;
      e.kind  = k;
      e.start = s;
      e.width = w;
      exq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) step();
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         pv[k]   = 1'b0;
         st[k]   = 0;
         wexp[k] = 0;
      end
   end

   // kinds: 0 = S, 1 = R, 2 = conflict
   always @(negedge clk) begin
      ev_t e;
      cv[0] = bus.S;
      cv[1] = bus.R;
      cv[2] = bus.conflict;
      chk("s_and_r", int'(bus.S & bus.R), 0);
      chk("conf_and_sr", int'(bus.conflict & (bus.S | bus.R)), 0);
      for (int k = 0; k < 3; k++) begin
         if (cv[k] && !pv[k]) begin
            if (exq.size() == 0) begin
               chk($sformatf("unexpected_k%0d_at", k), cyc, 0);
            end else begin
               e = exq.pop_front();
               chk("ev_kind", k, e.kind);
               chk($sformatf("ev_start_k%0d", k), cyc, e.start);
               wexp[k] = e.width;
               st[k]   = cyc;
            end
         end
         if (!cv[k] && pv[k])
            chk($sformatf("ev_width_k%0d", k), cyc - st[k], wexp[k]);
         pv[k] = cv[k];
      end
   end

   int t0;
   int t1;
   int t2;
   int t3;

   initial begin
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      bus.btn_set = 1'b0;
      bus.btn_rst = 1'b0;
      repeat (3) step();
      chk("rst_S", int'(bus.S), 0);
      chk("rst_R", int'(bus.R), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_conf", int'(bus.conflict), 0);
      rst_n = 1'b1;
      repeat (5) step();

      // clean set press held 20 cycles
      t0 = cyc + 1;
      bus.btn_set = 1'b1;
      push(0, t0 + 7, 2);
      wait_to(t0 + 6);
      chk("a_busy_pre", int'(bus.busy), 0);
      chk("a_S_pre", int'(bus.S), 0);
      wait_to(t0 + 7);
      chk("a_busy_on", int'(bus.busy), 1);
      chk("a_S_on", int'(bus.S), 1);
      wait_to(t0 + 9);
      chk("a_S_off", int'(bus.S), 0);
      chk("a_busy_hold", int'(bus.busy), 1);
      wait_to(t0 + 19);
      bus.btn_set = 1'b0;
      t1 = t0 + 20;
      wait_to(t1 + 6);
      chk("a_busy_rel", int'(bus.busy), 1);
      wait_to(t1 + 7);
      chk("a_busy_idle", int'(bus.busy), 0);
      repeat (3) step();
      chk("a_pending", exq.size(), 0);

      // 3-cycle glitch, then 10 cycles of toggling
      bus.btn_set = 1'b1;
      repeat (3) step();
      bus.btn_set = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         bus.btn_set = ~bus.btn_set;
         chk("b_busy", int'(bus.busy), 0);
      end
      bus.btn_set = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("b_busy_tail", int'(bus.busy), 0);
      end

      // simultaneous set and reset
      t0 = cyc + 1;
      bus.btn_set = 1'b1;
      bus.btn_rst = 1'b1;
      push(2, t0 + 7, 1);
      wait_to(t0 + 7);
      chk("c_conf", int'(bus.conflict), 1);
      chk("c_busy", int'(bus.busy), 1);
      wait_to(t0 + 8);
      chk("c_conf_off", int'(bus.conflict), 0);
      wait_to(t0 + 11);
      bus.btn_set = 1'b0;
      bus.btn_rst = 1'b0;
      t1 = t0 + 12;
      wait_to(t1 + 6);
      chk("c_busy_rel", int'(bus.busy), 1);
      wait_to(t1 + 7);
      chk("c_busy_idle", int'(bus.busy), 0);
      repeat (3) step();
      chk("c_pending", exq.size(), 0);

      // reset button pressed during the set pulse
      t0 = cyc + 1;
      bus.btn_set = 1'b1;
      push(0, t0 + 7, 2);
      wait_to(t0 + 6);
      bus.btn_rst = 1'b1;
      wait_to(t0 + 19);
      bus.btn_set = 1'b0;
      wait_to(t0 + 35);
      chk("d_busy_held", int'(bus.busy), 1);
      chk("d_R_held", int'(bus.R), 0);
      bus.btn_rst = 1'b0;
      t2 = t0 + 36;
      wait_to(t2 + 7);
      chk("d_busy_idle", int'(bus.busy), 0);
      wait_to(t2 + 9);
      bus.btn_rst = 1'b1;
      t3 = t2 + 10;
      push(1, t3 + 7, 2);
      wait_to(t3 + 7);
      chk("d_R_on", int'(bus.R), 1);
      chk("d_S_off", int'(bus.S), 0);
      wait_to(t3 + 14);
      bus.btn_rst = 1'b0;
      repeat (12) step();
      chk("d_busy_end", int'(bus.busy), 0);
      chk("d_pending", exq.size(), 0);

      // reset during the second S cycle, button held through it
      t0 = cyc + 1;
      bus.btn_set = 1'b1;
      push(0, t0 + 7, 1);
      wait_to(t0 + 7);
      chk("e_S_first", int'(bus.S), 1);
      rst_n = 1'b0;
      wait_to(t0 + 8);
      chk("e_S_rst", int'(bus.S), 0);
      chk("e_busy_rst", int'(bus.busy), 0);
      wait_to(t0 + 9);
      rst_n = 1'b1;
      t1 = t0 + 10;
      push(0, t1 + 7, 2);
      wait_to(t1 + 6);
      chk("e_S_pre", int'(bus.S), 0);
      chk("e_busy_pre", int'(bus.busy), 0);
      wait_to(t1 + 7);
      chk("e_S_new", int'(bus.S), 1);
      wait_to(t1 + 12);
      bus.btn_set = 1'b0;
      repeat (12) step();
      chk("e_busy_end", int'(bus.busy), 0);
      chk("e_pending", exq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
